// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH controller and its GF(2^128) multiplier.
package ghash_pkg;

    localparam int BLK_W = 128;
    localparam int LEN_W = 64;
    localparam int CNT_W = 32;

    // Reduction constant for the bit-reflected GCM field: x^128 + x^7 + x^2 + x + 1
    localparam logic [BLK_W-1:0] GF_R = {8'he1, 120'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_CT,
        S_LEN,
        S_MUL,
        S_DONE
    } state_t;

    // Number of 128-bit blocks needed to carry len bits
    function automatic logic [CNT_W-1:0] num_blocks(input logic [LEN_W-1:0] len);
        return CNT_W'((len + 64'd127) >> 7);
    endfunction

endpackage

// File: rtl/ghash_block_v2.sv
// Bit-serial GF(2^128) multiplier: oY = (iCtext ^ iY) * H, one result bit-step per clock.
module ghash_block_v2
    import ghash_pkg::*;
(
    input  logic             iClk,
    input  logic             iRstn,
    input  logic [BLK_W-1:0] iHashkey,
    input  logic             iHashkey_valid,
    input  logic [BLK_W-1:0] iY,
    input  logic [BLK_W-1:0] iCtext,
    input  logic             iCtext_valid,
    output logic [BLK_W-1:0] oY,
    output logic             oY_valid
);

    logic [BLK_W-1:0] h;
    logic [BLK_W-1:0] x;
    logic [BLK_W-1:0] v;
    logic [BLK_W-1:0] z;
    logic [BLK_W-1:0] z_next;
    logic [BLK_W-1:0] v_next;
    logic [6:0]       step;
    logic             run;

    // One step of the shift-and-add multiply; the leftmost bit is the x^0 coefficient
    always_comb begin
        z_next = x[BLK_W-1] ? (z ^ v) : z;
        v_next = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end

    // Datapath registers: hash key, operand, running product and result
    always_ff @(posedge iClk) begin
        if (iHashkey_valid) h <= iHashkey;
        if (iCtext_valid) begin
            x <= iCtext ^ iY;
            v <= h;
            z <= '0;
        end else if (run) begin
            x <= x << 1;
            v <= v_next;
            z <= z_next;
            if (step == 7'd127) oY <= z_next;
        end
    end

    // Sequencing: 128 steps after a start, then a one-cycle result strobe
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            run      <= 1'b0;
            step     <= '0;
            oY_valid <= 1'b0;
        end else begin
            oY_valid <= 1'b0;
            if (iCtext_valid) begin
                run  <= 1'b1;
                step <= '0;
            end else if (run) begin
                step <= step + 7'd1;
                if (step == 7'd127) begin
                    run      <= 1'b0;
                    oY_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ghash_ctrl.sv
// GCM tag controller: sequences AAD, ciphertext and length blocks through the GHASH multiplier.
module ghash_ctrl
    import ghash_pkg::*;
(
    input  logic             iClk,
    input  logic             iRstn,
    input  logic [0:BLK_W-1] iHashkey,
    input  logic             iHashkey_valid,
    input  logic             iStart,
    input  logic [0:LEN_W-1] iAad_len,
    input  logic [0:LEN_W-1] iCt_len,
    input  logic [0:BLK_W-1] iEky0,
    input  logic [0:BLK_W-1] iBlock,
    input  logic             iBlock_valid,
    output logic             oBlock_ready,
    output logic [0:BLK_W-1] oTag,
    output logic             oTag_valid,
    output logic             oBusy
);

    state_t           state;
    state_t           seg;
    logic [LEN_W-1:0] aad_len;
    logic [LEN_W-1:0] ct_len;
    logic [BLK_W-1:0] eky0;
    logic [BLK_W-1:0] y;
    logic [BLK_W-1:0] blk;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_c;
    logic             mul_go;
    logic [BLK_W-1:0] mul_y;
    logic             mul_y_valid;

    logic [CNT_W-1:0] n_a_in;
    logic [CNT_W-1:0] n_c_in;
    logic [6:0]       tail;
    logic [BLK_W-1:0] masked;
    logic             start_ok;
    logic             accept;

    // Block counts of a new message, and zero-masking of a partial final block
    always_comb begin
        n_a_in   = num_blocks(iAad_len);
        n_c_in   = num_blocks(iCt_len);
        start_ok = iStart && !oBusy && (state == S_IDLE || state == S_DONE);
        accept   = iBlock_valid && oBlock_ready;
        tail     = (state == S_AAD) ? aad_len[6:0] : ct_len[6:0];
        masked   = iBlock;
        if (cnt == 32'd1 && tail != 7'd0)
            masked = iBlock & ~({BLK_W{1'b1}} >> tail);
    end

    // Message parameters and the operand handed to the multiplier
    always_ff @(posedge iClk) begin
        if (start_ok) begin
            aad_len <= iAad_len;
            ct_len  <= iCt_len;
            eky0    <= iEky0;
        end
        if (accept)
            blk <= masked;
        else if (state == S_LEN)
            blk <= {aad_len, ct_len};
    end

    // Main sequencer with registered handshake and tag outputs
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state        <= S_IDLE;
            seg          <= S_IDLE;
            cnt          <= '0;
            n_c          <= '0;
            y            <= '0;
            mul_go       <= 1'b0;
            oTag         <= '0;
            oTag_valid   <= 1'b0;
            oBlock_ready <= 1'b0;
            oBusy        <= 1'b0;
        end else begin
            mul_go <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        y          <= '0;
                        oTag_valid <= 1'b0;
                        oBusy      <= 1'b1;
                        n_c        <= n_c_in;
                        if (n_a_in != '0) begin
                            state        <= S_AAD;
                            cnt          <= n_a_in;
                            oBlock_ready <= 1'b1;
                        end else if (n_c_in != '0) begin
                            state        <= S_CT;
                            cnt          <= n_c_in;
                            oBlock_ready <= 1'b1;
                        end else begin
                            state <= S_LEN;
                            cnt   <= '0;
                        end
                    end
                end
                S_AAD, S_CT: begin
                    if (accept) begin
                        oBlock_ready <= 1'b0;
                        mul_go       <= 1'b1;
                        seg          <= state;
                        state        <= S_MUL;
                    end
                end
                S_LEN: begin
                    mul_go <= 1'b1;
                    seg    <= S_LEN;
                    state  <= S_MUL;
                end
                S_MUL: begin
                    if (mul_y_valid) begin
                        y   <= mul_y;
                        cnt <= cnt - 32'd1;
                        case (seg)
                            S_AAD: begin
                                if (cnt != 32'd1) begin
                                    state        <= S_AAD;
                                    oBlock_ready <= 1'b1;
                                end else if (n_c != '0) begin
                                    state        <= S_CT;
                                    cnt          <= n_c;
                                    oBlock_ready <= 1'b1;
                                end else begin
                                    state <= S_LEN;
                                end
                            end
                            S_CT: begin
                                if (cnt != 32'd1) begin
                                    state        <= S_CT;
                                    oBlock_ready <= 1'b1;
                                end else begin
                                    state <= S_LEN;
                                end
                            end
                            default: begin
                                cnt        <= '0;
                                state      <= S_DONE;
                                oTag       <= mul_y ^ eky0;
                                oTag_valid <= 1'b1;
                                oBusy      <= 1'b0;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ghash_block_v2 u_mul (
        .iClk           (iClk),
        .iRstn          (iRstn),
        .iHashkey       (iHashkey),
        .iHashkey_valid (iHashkey_valid),
        .iY             (y),
        .iCtext         (blk),
        .iCtext_valid   (mul_go),
        .oY             (mul_y),
        .oY_valid       (mul_y_valid)
    );

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: expected tags are queued at message start and
// checked by an independent monitor whenever oTag_valid rises.
module tb_ghash_ctrl;

    localparam int MUL_LAT = 128;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [127:0] hashkey = '0;
    logic         hashkey_valid = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  aad_len = '0;
    logic [63:0]  ct_len = '0;
    logic [127:0] eky0 = '0;
    logic [127:0] blk = '0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [127:0] tag;
    logic         tag_valid;
    logic         busy;

    ghash_ctrl dut (
        .iClk           (clk),
        .iRstn          (rstn),
        .iHashkey       (hashkey),
        .iHashkey_valid (hashkey_valid),
        .iStart         (start),
        .iAad_len       (aad_len),
        .iCt_len        (ct_len),
        .iEky0          (eky0),
        .iBlock         (blk),
        .iBlock_valid   (blk_valid),
        .oBlock_ready   (blk_ready),
        .oTag           (tag),
        .oTag_valid     (tag_valid),
        .oBusy          (busy)
    );

    always #5 clk = ~clk;

    int           n_pass = 0;
    int           n_total = 0;
    int           acc_cnt = 0;
    logic         tag_prev = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] cur_aad[$];
    logic [127:0] cur_ct[$];
    logic [127:0] model_h = '0;

    localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] H4   = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] EK4  = 128'h3247184b3c4f69a44dbcd22887bbb418;
    localparam logic [127:0] T4   = 128'h5bc94fbc3221a5db94fae95ae7121a47;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // GF(2^128) product via carry-less multiply of bit-reflected operands and polynomial reduction
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] prod;
        logic [127:0] ar, br, res;
        prod = '0;
        for (int i = 0; i < 128; i++) begin
            ar[i] = a[127-i];
            br[i] = b[127-i];
        end
        for (int i = 0; i < 128; i++)
            if (ar[i]) prod = prod ^ (255'(br) << i);
        for (int k = 254; k >= 128; k--)
            if (prod[k]) prod = prod ^ (255'({1'b1, 120'd0, 8'b1000_0111}) << (k - 128));
        for (int i = 0; i < 128; i++) res[127-i] = prod[i];
        return res;
    endfunction

    // Zero-pad the bytes of a final block that lie beyond the segment length
    function automatic logic [127:0] pad_block(input logic [127:0] b, input logic [63:0] len, input bit last);
        logic [127:0] r;
        int nb;
        r  = b;
        nb = int'((len >> 3) % 64'd16);
        if (last && nb != 0)
            for (int k = nb; k < 16; k++) r[127-8*k -: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [127:0] ref_tag(input logic [63:0] al, input logic [63:0] cl, input logic [127:0] ek);
        logic [127:0] acc;
        acc = '0;
        for (int i = 0; i < cur_aad.size(); i++)
            acc = gf_mul(acc ^ pad_block(cur_aad[i], al, i == cur_aad.size() - 1), model_h);
        for (int i = 0; i < cur_ct.size(); i++)
            acc = gf_mul(acc ^ pad_block(cur_ct[i], cl, i == cur_ct.size() - 1), model_h);
        acc = gf_mul(acc ^ {al, cl}, model_h);
        return acc ^ ek;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every rising oTag_valid is matched against the oldest expected tag
    always @(negedge clk) begin
        if (!rstn) begin
            tag_prev = 1'b0;
        end else begin
            if (tag_valid && !tag_prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tag_unexpected: got %h, want no tag", tag);
                end else begin
                    check("tag", tag, exp_q.pop_front());
                end
            end
            tag_prev = tag_valid;
        end
    end

    always @(posedge clk) if (rstn && blk_valid && blk_ready) acc_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_h(input logic [127:0] h);
        hashkey       = h;
        hashkey_valid = 1'b1;
        model_h       = h;
        step();
        hashkey_valid = 1'b0;
    endtask

    task automatic set_rand_msg(input int al_bytes, input int cl_bytes);
        cur_aad.delete();
        cur_ct.delete();
        for (int i = 0; i < (al_bytes + 15) / 16; i++) cur_aad.push_back(rnd128());
        for (int i = 0; i < (cl_bytes + 15) / 16; i++) cur_ct.push_back(rnd128());
    endtask

    task automatic send_msg(input logic [63:0] al, input logic [63:0] cl, input logic [127:0] ek,
                            input logic [127:0] exp_tag, input bit toggle, input bit poke,
                            input bit chk_drop, input bit lat_chk);
        logic [127:0] all_q[$];
        int budget;
        int acc0;
        bit done;
        budget = 0;
        while (busy && budget < 2000) begin
            step();
            budget++;
        end
        if (busy) begin
            n_total++;
            $display("FAIL start_wait: busy %b, want 0", busy);
        end
        all_q = {cur_aad, cur_ct};
        acc0    = acc_cnt;
        aad_len = al;
        ct_len  = cl;
        eky0    = ek;
        start   = 1'b1;
        exp_q.push_back(exp_tag);
        step();
        start   = 1'b0;
        aad_len = {$urandom, $urandom};
        ct_len  = {$urandom, $urandom};
        eky0    = rnd128();
        if (chk_drop) check("tag_valid_drop", 128'(tag_valid), 128'd0);
        check("busy_after_start", 128'(busy), 128'd1);
        for (int idx = 0; idx < all_q.size(); idx++) begin
            done   = 1'b0;
            budget = 0;
            while (!done) begin
                blk_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                blk       = blk_valid ? all_q[idx] : rnd128();
                if (poke && $urandom_range(0, 3) == 0) begin
                    start   = 1'b1;
                    aad_len = 64'($urandom_range(0, 400)) << 3;
                    ct_len  = 64'($urandom_range(0, 400)) << 3;
                    eky0    = rnd128();
                end
                done = blk_valid && blk_ready;
                step();
                start = 1'b0;
                budget++;
                if (budget > 1000) begin
                    n_total++;
                    $display("FAIL block_accept_timeout: block %0d not accepted, want accepted", idx);
                    blk_valid = 1'b0;
                    return;
                end
            end
            blk_valid = 1'b0;
            if (lat_chk && idx == 0) begin
                budget = 0;
                while (!blk_ready && budget < 1000) begin
                    step();
                    budget++;
                end
                check("block_latency", 128'(budget), 128'(1 + MUL_LAT + 1));
            end
        end
        blk_valid = 1'b0;
        budget = 0;
        while (!tag_valid && budget < 1000) begin
            step();
            budget++;
        end
        if (!tag_valid) begin
            n_total++;
            $display("FAIL tag_timeout: tag_valid 0, want 1");
        end
        check("accepts", 128'(acc_cnt - acc0), 128'(all_q.size()));
    endtask

    task automatic set_tc2();
        cur_aad.delete();
        cur_ct.delete();
        cur_ct.push_back(C1);
    endtask

    task automatic set_tc4();
        cur_aad.delete();
        cur_ct.delete();
        cur_aad.push_back(128'hfeedfacedeadbeeffeedfacedeadbeef);
        cur_aad.push_back(128'habaddad20123456789abcdeffedcba98);
        cur_ct.push_back(128'h42831ec2217774244b7221b784d0d49c);
        cur_ct.push_back(128'he3aa212f2c02a4e035c17e2329aca12e);
        cur_ct.push_back(128'h21d514b25466931c7d8f6a5aac84aa05);
        cur_ct.push_back(128'h1ba30b396a0aac973d58e0915a5a5a5a);
    endtask

    initial begin
        int al_b, cl_b, budget;
        logic [127:0] ek;

        // Reset state
        #1 rstn = 1'b0;
        #2;
        check("rst_tag", tag, 128'd0);
        check("rst_tag_valid", 128'(tag_valid), 128'd0);
        check("rst_ready", 128'(blk_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        step();

        // Empty message: only the length block
        load_h(H1);
        cur_aad.delete();
        cur_ct.delete();
        send_msg(64'd0, 64'd0, EK1, EK1, 1'b0, 1'b0, 1'b0, 1'b0);

        // One full ciphertext block
        set_tc2();
        send_msg(64'd0, 64'd128, EK1, T2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Partial AAD and ciphertext tails carrying garbage, with latency measurement
        load_h(H4);
        set_tc4();
        send_msg(64'd160, 64'd480, EK4, T4, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random valid gaps and iStart pulses while busy
        set_tc4();
        send_msg(64'd160, 64'd480, EK4, T4, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        check("busy_after_poked_msg", 128'(busy), 128'd0);
        check("tag_held", tag, T4);

        // Reset while a multiply is in flight
        load_h(H1);
        aad_len = 64'd0;
        ct_len  = 64'd128;
        eky0    = EK1;
        start   = 1'b1;
        step();
        start     = 1'b0;
        blk       = C1;
        blk_valid = 1'b1;
        budget    = 0;
        while (!blk_ready && budget < 100) begin
            step();
            budget++;
        end
        step();
        blk_valid = 1'b0;
        repeat (20) step();
        check("busy_in_mul", 128'(busy), 128'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_tag", tag, 128'd0);
        check("midrst_tag_valid", 128'(tag_valid), 128'd0);
        check("midrst_ready", 128'(blk_ready), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (MUL_LAT + 20) step();
        check("no_late_tag", 128'(tag_valid), 128'd0);
        check("idle_after_abort", 128'(busy), 128'd0);
        load_h(H1);
        set_tc2();
        send_msg(64'd0, 64'd128, EK1, T2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: second iStart issued while in DONE
        al_b = 13;
        cl_b = 21;
        set_rand_msg(al_b, cl_b);
        ek = rnd128();
        send_msg(64'(al_b) << 3, 64'(cl_b) << 3, ek, ref_tag(64'(al_b) << 3, 64'(cl_b) << 3, ek),
                 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized messages against the reference model
        for (int m = 0; m < 10; m++) begin
            if (m % 3 == 0) load_h(rnd128());
            al_b = $urandom_range(0, 40);
            cl_b = $urandom_range(0, 70);
            set_rand_msg(al_b, cl_b);
            ek = rnd128();
            send_msg(64'(al_b) << 3, 64'(cl_b) << 3, ek, ref_tag(64'(al_b) << 3, 64'(cl_b) << 3, ek),
                     1'(m % 2), 1'b0, 1'(m % 4 == 1), 1'b0);
        end

        repeat (5) step();
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
